// File: rtl/cpu7_ifu_dbuf.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO of {inst, pc, excp}.
// Define CPU7_IFU_DBUF_BYPASS_EN to forward fetch straight to decode when empty.
`ifndef GRLEN
`define GRLEN 32
`endif

module cpu7_ifu_dbuf #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fdp_dec_valid,
  input  logic [31:0]             fdp_dec_inst,
  input  logic [`GRLEN-1:0]       fdp_dec_pc,
  input  logic                    fdp_dec_excp,
  output logic                    dec_fdp_ready,
  input  logic                    exu_ifu_stall,
  input  logic                    exu_ifu_flush,
  output logic                    ifu_exu_valid_d,
  output logic [31:0]             ifu_exu_inst_d,
  output logic [`GRLEN-1:0]       ifu_exu_pc_d,
  output logic                    ifu_exu_excp_d,
  output logic [$clog2(DEPTH):0]  dbuf_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]       mem_inst [DEPTH];
  logic [`GRLEN-1:0] mem_pc   [DEPTH];
  logic              mem_excp [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic head_valid;
  logic byp;
  logic push;
  logic pop;
  logic buf_push;
  logic buf_pop;

  // Handshake: fetch->buffer transfers on fdp_dec_valid && dec_fdp_ready,
  // buffer->decode transfers on ifu_exu_valid_d && !exu_ifu_stall; flush kills both.
  assign dec_fdp_ready = (cnt != FULL_CNT);
  assign dbuf_cnt      = cnt;

  always_comb begin
    head_valid = (cnt != '0) && !reset;
`ifdef CPU7_IFU_DBUF_BYPASS_EN
    byp = (cnt == '0) && fdp_dec_valid && !exu_ifu_flush && !reset;
`else
    byp = 1'b0;
`endif
    ifu_exu_valid_d = head_valid | byp;
    ifu_exu_inst_d  = byp ? fdp_dec_inst : mem_inst[rd_ptr];
    ifu_exu_pc_d    = byp ? fdp_dec_pc   : mem_pc[rd_ptr];
    ifu_exu_excp_d  = byp ? fdp_dec_excp : (head_valid & mem_excp[rd_ptr]);

    push     = fdp_dec_valid && dec_fdp_ready && !exu_ifu_flush && !reset;
    pop      = ifu_exu_valid_d && !exu_ifu_stall && !exu_ifu_flush;
    // A bypassed instruction consumed in the same cycle never lands in the buffer.
    buf_push = push && !(byp && pop);
    buf_pop  = pop && head_valid;
  end

  always_ff @(posedge clk) begin
    if (reset || exu_ifu_flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (buf_push) wr_ptr <= wr_ptr + PW'(1);
      if (buf_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({buf_push, buf_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (buf_push) begin
      mem_inst[wr_ptr] <= fdp_dec_inst;
      mem_pc[wr_ptr]   <= fdp_dec_pc;
      mem_excp[wr_ptr] <= fdp_dec_excp;
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_dbuf.sv
// Directed bench for cpu7_ifu_dbuf (DEPTH=2); honours CPU7_IFU_DBUF_BYPASS_EN.
`ifndef GRLEN
`define GRLEN 32
`endif

module tb_cpu7_ifu_dbuf;

  localparam int DEPTH = 2;
  localparam int GW = `GRLEN;

  logic              clk;
  logic              reset;
  logic              fdp_dec_valid;
  logic [31:0]       fdp_dec_inst;
  logic [GW-1:0]     fdp_dec_pc;
  logic              fdp_dec_excp;
  logic              dec_fdp_ready;
  logic              exu_ifu_stall;
  logic              exu_ifu_flush;
  logic              ifu_exu_valid_d;
  logic [31:0]       ifu_exu_inst_d;
  logic [GW-1:0]     ifu_exu_pc_d;
  logic              ifu_exu_excp_d;
  logic [$clog2(DEPTH):0] dbuf_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [GW+31:0] exp_q[$];

  cpu7_ifu_dbuf #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .fdp_dec_valid   (fdp_dec_valid),
    .fdp_dec_inst    (fdp_dec_inst),
    .fdp_dec_pc      (fdp_dec_pc),
    .fdp_dec_excp    (fdp_dec_excp),
    .dec_fdp_ready   (dec_fdp_ready),
    .exu_ifu_stall   (exu_ifu_stall),
    .exu_ifu_flush   (exu_ifu_flush),
    .ifu_exu_valid_d (ifu_exu_valid_d),
    .ifu_exu_inst_d  (ifu_exu_inst_d),
    .ifu_exu_pc_d    (ifu_exu_pc_d),
    .ifu_exu_excp_d  (ifu_exu_excp_d),
    .dbuf_cnt        (dbuf_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [GW-1:0] pc, input logic excp);
    fdp_dec_valid = 1'b1;
    fdp_dec_inst  = inst;
    fdp_dec_pc    = pc;
    fdp_dec_excp  = excp;
  endtask

  task automatic idle();
    fdp_dec_valid = 1'b0;
    fdp_dec_inst  = '0;
    fdp_dec_pc    = '0;
    fdp_dec_excp  = 1'b0;
  endtask

  initial begin
    int idx;
    int got;
    int cyc;
    logic [GW+31:0] exp_v;

    reset = 1'b1;
    exu_ifu_stall = 1'b0;
    exu_ifu_flush = 1'b0;
    idle();
    tick();
    offer(32'hDEAD_BEEF, GW'(32'h1234), 1'b1);
    #1;
    check("rst_valid", 64'(ifu_exu_valid_d), 64'd0);
    check("rst_ready", 64'(dec_fdp_ready), 64'd1);
    check("rst_excp", 64'(ifu_exu_excp_d), 64'd0);
    tick();
    check("rst_cnt", 64'(dbuf_cnt), 64'd0);
    reset = 1'b0;
    idle();
    #1;
    check("rst_valid_after", 64'(ifu_exu_valid_d), 64'd0);

    // single instruction, no stall
    offer(32'h0280_1C0C, GW'(32'h1C00_0000), 1'b0);
    #1;
`ifdef CPU7_IFU_DBUF_BYPASS_EN
    check("t1_byp_valid", 64'(ifu_exu_valid_d), 64'd1);
    check("t1_byp_inst", 64'(ifu_exu_inst_d), 64'h0280_1C0C);
    check("t1_byp_pc", 64'(ifu_exu_pc_d), 64'h1C00_0000);
    tick();
    idle();
    #1;
    check("t1_cnt", 64'(dbuf_cnt), 64'd0);
    check("t1_valid_after", 64'(ifu_exu_valid_d), 64'd0);
`else
    check("t1_valid_same", 64'(ifu_exu_valid_d), 64'd0);
    tick();
    idle();
    #1;
    check("t1_valid", 64'(ifu_exu_valid_d), 64'd1);
    check("t1_inst", 64'(ifu_exu_inst_d), 64'h0280_1C0C);
    check("t1_pc", 64'(ifu_exu_pc_d), 64'h1C00_0000);
    check("t1_cnt1", 64'(dbuf_cnt), 64'd1);
    tick();
    check("t1_cnt", 64'(dbuf_cnt), 64'd0);
    check("t1_valid_after", 64'(ifu_exu_valid_d), 64'd0);
`endif

    // stalled fill: A, B accepted; C held by fetch
    exu_ifu_stall = 1'b1;
    offer(32'h0000_00AA, GW'(32'h100), 1'b0);
    tick();
    offer(32'h0000_00BB, GW'(32'h104), 1'b0);
    tick();
    offer(32'h0000_00CC, GW'(32'h108), 1'b0);
    #1;
    check("t2_ready", 64'(dec_fdp_ready), 64'd0);
    check("t2_cnt", 64'(dbuf_cnt), 64'd2);
    check("t2_head_pc", 64'(ifu_exu_pc_d), 64'h100);
    tick();
    check("t2_cnt_held", 64'(dbuf_cnt), 64'd2);
    check("t2_head_stable", 64'(ifu_exu_inst_d), 64'hAA);

    // release stall one cycle: A pops, ready comes back next cycle
    exu_ifu_stall = 1'b0;
    #1;
    check("t3_ready_same", 64'(dec_fdp_ready), 64'd0);
    tick();
    exu_ifu_stall = 1'b1;
    #1;
    check("t3_ready_next", 64'(dec_fdp_ready), 64'd1);
    check("t3_cnt1", 64'(dbuf_cnt), 64'd1);
    check("t3_head_b", 64'(ifu_exu_pc_d), 64'h104);
    tick();
    idle();
    check("t3_cnt2", 64'(dbuf_cnt), 64'd2);
    exu_ifu_stall = 1'b0;
    #1;
    check("t3_head_b2", 64'(ifu_exu_inst_d), 64'hBB);
    tick();
    check("t3_head_c", 64'(ifu_exu_inst_d), 64'hCC);
    check("t3_pc_c", 64'(ifu_exu_pc_d), 64'h108);
    tick();
    check("t3_empty", 64'(dbuf_cnt), 64'd0);

    // flush a full buffer while fetch offers F
    exu_ifu_stall = 1'b1;
    offer(32'h0000_00DD, GW'(32'h200), 1'b0);
    tick();
    offer(32'h0000_00EE, GW'(32'h204), 1'b0);
    tick();
    check("t4_full", 64'(dbuf_cnt), 64'd2);
    offer(32'h0000_00FF, GW'(32'h208), 1'b0);
    exu_ifu_flush = 1'b1;
    tick();
    exu_ifu_flush = 1'b0;
    idle();
    #1;
    check("t4_cnt", 64'(dbuf_cnt), 64'd0);
    check("t4_valid", 64'(ifu_exu_valid_d), 64'd0);
    check("t4_ready", 64'(dec_fdp_ready), 64'd1);
    check("t4_excp", 64'(ifu_exu_excp_d), 64'd0);
    exu_ifu_stall = 1'b0;
    tick();
    check("t4_no_emit", 64'(ifu_exu_valid_d), 64'd0);

    // exception tag belongs to one entry only
    exu_ifu_stall = 1'b1;
    offer(32'h0000_0111, GW'(32'h300), 1'b1);
    tick();
    offer(32'h0000_0222, GW'(32'h304), 1'b0);
    tick();
    idle();
    #1;
    check("t5_excp1", 64'(ifu_exu_excp_d), 64'd1);
    check("t5_pc1", 64'(ifu_exu_pc_d), 64'h300);
    exu_ifu_stall = 1'b0;
    tick();
    check("t5_excp2", 64'(ifu_exu_excp_d), 64'd0);
    check("t5_pc2", 64'(ifu_exu_pc_d), 64'h304);
    tick();
    check("t5_empty", 64'(dbuf_cnt), 64'd0);

    // stream 8 instructions with random stall
    idx = 0;
    got = 0;
    cyc = 0;
    while ((idx < 8 || got < 8) && cyc < 200) begin
      exu_ifu_stall = 1'($urandom_range(0, 1));
      if (idx < 8) offer(32'hA000_0000 + 32'(idx), GW'(32'h1C00_0400) + GW'(idx * 4), 1'b0);
      else idle();
      #1;
      if (fdp_dec_valid && dec_fdp_ready) begin
        exp_q.push_back({fdp_dec_pc, fdp_dec_inst});
        idx++;
      end
      if (ifu_exu_valid_d && !exu_ifu_stall) begin
        if (exp_q.size() == 0) begin
          check("t6_unexpected", 64'(ifu_exu_inst_d), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_v = exp_q.pop_front();
          check("t6_inst", 64'(ifu_exu_inst_d), 64'(exp_v[31:0]));
          check("t6_pc", 64'(ifu_exu_pc_d), 64'(exp_v[GW+31:32]));
        end
        got++;
      end
      tick();
      cyc++;
    end
    idle();
    exu_ifu_stall = 1'b0;
    check("t6_timeout", 64'(cyc < 200), 64'd1);
    check("t6_count", 64'(got), 64'd8);
    #1;
    check("t6_cnt", 64'(dbuf_cnt), 64'd0);

    // reset mid-operation discards entries
    exu_ifu_stall = 1'b1;
    offer(32'h0000_0333, GW'(32'h500), 1'b0);
    tick();
    idle();
    check("t7_cnt_pre", 64'(dbuf_cnt), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t7_cnt", 64'(dbuf_cnt), 64'd0);
    check("t7_valid", 64'(ifu_exu_valid_d), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_dbuf.md
CPU7_IFU_DBUF -- requirements
Module: cpu7_ifu_dbuf

Interface
REQ-001 The block SHALL take parameter DEPTH, default 2, as the number of buffer entries; it SHALL be a power of two and at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fdp_dec_valid  input  1  fetch presents an instruction.
REQ-005 fdp_dec_inst  input  32  fetched instruction word.
REQ-006 fdp_dec_pc  input  `GRLEN  PC of the fetched instruction.
REQ-007 fdp_dec_excp  input  1  fetch-side exception tag (e.g. ADEF).
REQ-008 dec_fdp_ready  output  1  buffer can accept an instruction this cycle.
REQ-009 exu_ifu_stall  input  1  decode/execute cannot consume this cycle.
REQ-010 exu_ifu_flush  input  1  branch or exception redirect; discard all buffered instructions.
REQ-011 ifu_exu_valid_d  output  1  decode-stage instruction valid; drives the immediate-decode path.
REQ-012 ifu_exu_inst_d  output  32  decode-stage instruction word.
REQ-013 ifu_exu_pc_d  output  `GRLEN  decode-stage PC.
REQ-014 ifu_exu_excp_d  output  1  decode-stage exception tag.
REQ-015 dbuf_cnt  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 The block SHALL be a FIFO of DEPTH entries; each entry holds {inst, pc, excp}.
REQ-017 Push SHALL occur when fdp_dec_valid && dec_fdp_ready && !exu_ifu_flush.
REQ-018 Pop SHALL occur when ifu_exu_valid_d && !exu_ifu_stall && !exu_ifu_flush.
REQ-019 dec_fdp_ready SHALL be a function of registered state only: it SHALL equal (dbuf_cnt != DEPTH).
REQ-020 When the buffer is non-empty, ifu_exu_valid_d SHALL be 1 and the data outputs SHALL present the head entry combinationally.
REQ-021 Simultaneous push and pop SHALL leave dbuf_cnt unchanged; the head advances and the tail advances.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 When full, no push SHALL occur; a pop in that cycle SHALL make dec_fdp_ready 1 in the following cycle, not the same cycle.
REQ-024 Flush SHALL take priority over push and pop. On the next edge, dbuf_cnt and both pointers SHALL be 0, and the instruction offered in the flush cycle SHALL be dropped.
REQ-025 While exu_ifu_stall is 1, all head outputs SHALL hold stable.
REQ-026 Entry contents SHALL be written only on push; no datapath reset is required. ifu_exu_inst_d, ifu_exu_pc_d and ifu_exu_excp_d are don't-care while ifu_exu_valid_d is 0, except that ifu_exu_excp_d SHALL be 0 whenever ifu_exu_valid_d is 0.

Reset
REQ-027 While reset is 1, the block SHALL clear dbuf_cnt and both pointers to 0, drive ifu_exu_valid_d to 0 and dec_fdp_ready to 1, and ignore push and pop.
REQ-028 Reset asserted mid-operation SHALL discard all entries on that edge, exactly like flush.

Configuration
REQ-029 Macro CPU7_IFU_DBUF_BYPASS_EN SHALL select the empty-buffer behaviour.
REQ-030 With the macro defined and the buffer empty, fdp_dec_valid && !exu_ifu_flush SHALL drive ifu_exu_valid_d=1 and forward the fetch inputs combinationally in the same cycle. If that instruction is also popped, it SHALL NOT be written into the buffer; otherwise it SHALL be pushed.
REQ-031 Without the macro, fetch-to-decode latency SHALL be exactly one cycle: the output is driven only from buffer entries.

Verification
REQ-032 Reset, then inst 0x02801C0C at pc 0x1C000000 with no stall -> ifu_exu_valid_d=1 with that inst/pc one cycle later (same cycle with BYPASS_EN); dbuf_cnt returns to 0.
REQ-033 Hold exu_ifu_stall=1 and push 3 instructions (DEPTH=2) -> dec_fdp_ready=0 after 2 pushes, the 3rd is held by fetch, the head stays on the first pc, dbuf_cnt=2.
REQ-034 Full buffer, release stall for 1 cycle -> the first instruction pops, dec_fdp_ready=1 on the next cycle, the 3rd is accepted, order is preserved.
REQ-035 Full buffer with exu_ifu_flush=1 while fdp_dec_valid=1 -> next cycle dbuf_cnt=0, ifu_exu_valid_d=0, and the offered instruction is never emitted.
REQ-036 Push with fdp_dec_excp=1 -> ifu_exu_excp_d=1 only for that entry; the following entry shows 0.
REQ-037 Stream 8 instructions with random stall -> the output sequence exactly equals the input sequence; pointers wrap without loss or duplication.
